mulu_m2q2_seq: RTL

- Sequencer that builds a WIDTH x WIDTH unsigned multiply out of the 2x2 unsigned multiplier core (mulu_m2q2), time-multiplexing it over all digit pairs.
- Operands arrive serially, one 2-bit digit per cycle on the existing 2-bit x/y pin pairs.
- The 2*WIDTH-bit product streams out one 4-bit nibble per cycle on the 4-bit product pins.
- Sits between the top-level io_in/io_out pin mapping and a single combinational mulu_m2q2 instance.

---
 rtl/mulu_m2q2_seq_if.sv | 25 ++
 rtl/mulu_m2q2_seq.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mulu_m2q2_seq_if.sv
// Handshake and datapath pins of the digit-serial multiply sequencer:
// serial operand digits in, nibble-serial product out, plus the 2x2 core link.
interface mulu_m2q2_seq_if;
  logic       start;
  logic [1:0] x_in;
  logic [1:0] y_in;
  logic [1:0] mul_x;
  logic [1:0] mul_y;
  logic [3:0] mul_p;
  logic [3:0] p_out;
  logic       p_valid;
  logic       busy;
  logic       rdy;

  // slave: the sequencer. master: the surrounding pin mapping and the 2x2 core.
  modport slave (
    input  start, x_in, y_in, mul_p,
    output mul_x, mul_y, p_out, p_valid, busy, rdy
  );

  modport master (
    output start, x_in, y_in, mul_p,
    input  mul_x, mul_y, p_out, p_valid, busy, rdy
  );
endinterface

// File: rtl/mulu_m2q2_seq.sv
// WIDTH x WIDTH unsigned multiply built by time-multiplexing one 2x2 core over all digit pairs.
// Start-to-ready is D + D*D + WIDTH/2 cycles; start is only honoured in IDLE.
module mulu_m2q2_seq #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  mulu_m2q2_seq_if.slave    bus
);

  localparam int D  = WIDTH / 2;
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST = IW'(D - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_OUT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    i_q, i_d;
  logic [IW-1:0]    j_q, j_d;
  int               shamt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  // j_q doubles as LOAD digit index, MUL inner index and OUT nibble index,
  // since all three phases step over exactly D positions.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    shamt   = 2 * (int'(i_q) + int'(j_q));

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x_d       = '0;
          y_d       = '0;
          x_d[1:0]  = bus.x_in;
          y_d[1:0]  = bus.y_in;
          acc_d     = '0;
          i_d       = '0;
          j_d       = IW'(1);
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        x_d[2*j_q +: 2] = bus.x_in;
        y_d[2*j_q +: 2] = bus.y_in;
        j_d             = j_q + 1'b1;
        if (j_q == LAST) begin
          j_d     = '0;
          i_d     = '0;
          state_d = S_MUL;
        end
      end

      S_MUL: begin
        acc_d = acc_q + (PW'(bus.mul_p) << shamt);
        j_d   = j_q + 1'b1;
        if (j_q == LAST) begin
          j_d = '0;
          i_d = i_q + 1'b1;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = S_OUT;
          end
        end
      end

      S_OUT: begin
        j_d = j_q + 1'b1;
        if (j_q == LAST) begin
          j_d     = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs: nothing here looks at start, x_in or y_in.
  assign bus.mul_x   = (state_q == S_MUL) ? x_q[2*i_q +: 2]   : 2'b00;
  assign bus.mul_y   = (state_q == S_MUL) ? y_q[2*j_q +: 2]   : 2'b00;
  assign bus.p_out   = (state_q == S_OUT) ? acc_q[4*j_q +: 4] : 4'h0;
  assign bus.p_valid = (state_q == S_OUT);
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.rdy     = (state_q == S_IDLE);

endmodule
